// File: rtl/wide_serial_adder_if.sv
// Request/response bundle for the digit-serial adder.
// Signal prefixes are from the adder's point of view.
interface wide_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_carry;
  logic             i_sub;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_sum;
  logic             o_carry;
  logic             o_overflow;

  modport master (
    output i_valid, i_a, i_b, i_carry, i_sub, i_ready,
    input  o_ready, o_valid, o_sum, o_carry, o_overflow
  );

  modport slave (
    input  i_valid, i_a, i_b, i_carry, i_sub, i_ready,
    output o_ready, o_valid, o_sum, o_carry, o_overflow
  );
endinterface

// File: rtl/wide_serial_adder.sv
// Digit-serial add/subtract: DIGIT bits per cycle, LSB digit first,
// producing a WIDTH-bit result after WIDTH/DIGIT cycles.
module wide_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 2
) (
  input logic               i_clk,
  input logic               i_rst,
  wide_serial_adder_if.slave bus
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic             r_valid;
  logic             r_ready;
  logic [CW-1:0]    r_count;

  logic [DIGIT-1:0]       w_aDigit;
  logic [DIGIT-1:0]       w_bDigit;
  logic [DIGIT:0]         w_digitFull;
  logic [WIDTH+DIGIT-1:0] w_sumShift;
  logic                   w_carryIntoMsb;
  logic                   w_lastDigit;

  // Operands shift right each cycle so the active digit is always at bit 0.
  assign w_aDigit    = r_a[DIGIT-1:0];
  assign w_bDigit    = r_b[DIGIT-1:0];
  assign w_digitFull = {1'b0, w_aDigit} + {1'b0, w_bDigit} + {{DIGIT{1'b0}}, r_carry};
  assign w_sumShift  = {w_digitFull[DIGIT-1:0], r_sum} >> DIGIT;
  assign w_lastDigit = (r_count == CW'(N - 1));

  // The carry into a bit equals sum ^ a ^ b at that bit position.
  assign w_carryIntoMsb = w_digitFull[DIGIT-1] ^ w_aDigit[DIGIT-1] ^ w_bDigit[DIGIT-1];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
      r_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.i_valid) begin
            r_a     <= bus.i_a;
            r_b     <= bus.i_sub ? ~bus.i_b : bus.i_b;
            r_carry <= bus.i_sub ? ~bus.i_carry : bus.i_carry;
            r_count <= '0;
            r_ready <= 1'b0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a     <= r_a >> DIGIT;
          r_b     <= r_b >> DIGIT;
          r_sum   <= w_sumShift[WIDTH-1:0];
          r_carry <= w_digitFull[DIGIT];
          if (w_lastDigit) begin
            r_cout  <= w_digitFull[DIGIT];
            r_ovf   <= w_carryIntoMsb ^ w_digitFull[DIGIT];
            r_valid <= 1'b1;
            r_state <= DONE;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        DONE: begin
          if (bus.i_ready) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_ready    = r_ready;
  assign bus.o_valid    = r_valid;
  assign bus.o_sum      = r_sum;
  assign bus.o_carry    = r_cout;
  assign bus.o_overflow = r_ovf;

endmodule

// File: tb/tb_wide_serial_adder.sv
// Directed checks of the digit-serial adder at DIGIT=2, plus a
// DIGIT sweep against an arithmetic reference model.
module tb_wide_serial_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         checkCount = 0;
  int         errorCount = 0;
  logic [2:0] sweepGo = '0;
  logic [2:0] sweepDone = '0;

  always #5 clk = ~clk;

  wide_serial_adder_if #(.WIDTH(16)) dutIf ();

  wide_serial_adder #(.WIDTH(16), .DIGIT(2)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (dutIf)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic void modelAdd(input logic [15:0] a, input logic [15:0] b,
                                   input logic cin, input logic sub,
                                   output logic [15:0] sum, output logic cout,
                                   output logic ovf);
    logic [15:0] bEff;
    logic [16:0] full;
    bEff = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bEff} + {16'b0, (sub ? ~cin : cin)};
    sum  = full[15:0];
    cout = full[16];
    ovf  = (a[15] == bEff[15]) && (full[15] != a[15]);
  endfunction

  // Accept one request, scramble the operands afterwards and wait for o_valid.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                               input logic cin, input logic sub,
                               output logic [15:0] sum, output logic cout,
                               output logic ovf, output int lat);
    @(negedge clk);
    dutIf.i_a     = a;
    dutIf.i_b     = b;
    dutIf.i_carry = cin;
    dutIf.i_sub   = sub;
    dutIf.i_valid = 1'b1;
    @(posedge clk);
    #1;
    dutIf.i_valid = 1'b0;
    dutIf.i_a     = ~a;
    dutIf.i_b     = ~b;
    dutIf.i_carry = ~cin;
    dutIf.i_sub   = ~sub;
    lat = 0;
    while (dutIf.o_valid !== 1'b1 && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
    sum  = dutIf.o_sum;
    cout = dutIf.o_carry;
    ovf  = dutIf.o_overflow;
  endtask

  task automatic completeHandshake();
    @(negedge clk);
    dutIf.i_ready = 1'b1;
    @(posedge clk);
    #1;
    dutIf.i_ready = 1'b0;
  endtask

  task automatic runVector(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic cin, input logic sub, input logic [15:0] expSum,
                           input logic expCout, input logic expOvf, input int expLat);
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          lat;
    applyStimulus(a, b, cin, sub, sum, cout, ovf, lat);
    checkOutput({tag, ".sum"}, 32'(sum), 32'(expSum));
    checkOutput({tag, ".carry"}, 32'(cout), 32'(expCout));
    checkOutput({tag, ".ovf"}, 32'(ovf), 32'(expOvf));
    checkOutput({tag, ".latency"}, 32'(lat), 32'(expLat));
    completeHandshake();
    checkOutput({tag, ".validDrop"}, 32'(dutIf.o_valid), 32'd0);
    checkOutput({tag, ".readyBack"}, 32'(dutIf.o_ready), 32'd1);
  endtask

  for (genvar g = 0; g < 3; g++) begin : gSweep
    localparam int D   = (g == 0) ? 1 : ((g == 1) ? 4 : 16);
    localparam int LAT = 16 / D;

    wide_serial_adder_if #(.WIDTH(16)) sIf ();

    wide_serial_adder #(.WIDTH(16), .DIGIT(D)) uDut (
      .i_clk(clk),
      .i_rst(rst),
      .bus  (sIf)
    );

    initial begin
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] expSum;
      logic        cin;
      logic        sub;
      logic        expC;
      logic        expO;
      int          lat;
      sIf.i_valid = 1'b0;
      sIf.i_ready = 1'b0;
      sIf.i_a     = '0;
      sIf.i_b     = '0;
      sIf.i_carry = 1'b0;
      sIf.i_sub   = 1'b0;
      wait (sweepGo[g] === 1'b1);
      for (int v = 0; v < 8; v++) begin
        a   = (v == 0) ? 16'h7FFF : 16'($urandom);
        b   = (v == 0) ? 16'h0001 : 16'($urandom);
        cin = (v == 0) ? 1'b0 : 1'($urandom);
        sub = 1'(v);
        modelAdd(a, b, cin, sub, expSum, expC, expO);
        @(negedge clk);
        sIf.i_a     = a;
        sIf.i_b     = b;
        sIf.i_carry = cin;
        sIf.i_sub   = sub;
        sIf.i_valid = 1'b1;
        @(posedge clk);
        #1;
        sIf.i_valid = 1'b0;
        sIf.i_a     = ~a;
        sIf.i_b     = ~b;
        lat = 0;
        while (sIf.o_valid !== 1'b1 && lat < 64) begin
          @(posedge clk);
          #1;
          lat++;
        end
        checkOutput($sformatf("D%0d.v%0d.sum", D, v), 32'(sIf.o_sum), 32'(expSum));
        checkOutput($sformatf("D%0d.v%0d.carry", D, v), 32'(sIf.o_carry), 32'(expC));
        checkOutput($sformatf("D%0d.v%0d.ovf", D, v), 32'(sIf.o_overflow), 32'(expO));
        checkOutput($sformatf("D%0d.v%0d.latency", D, v), 32'(lat), 32'(LAT));
        @(negedge clk);
        sIf.i_ready = 1'b1;
        @(posedge clk);
        #1;
        sIf.i_ready = 1'b0;
      end
      sweepDone[g] = 1'b1;
    end
  end

  initial begin
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          lat;
    dutIf.i_valid = 1'b0;
    dutIf.i_ready = 1'b0;
    dutIf.i_a     = '0;
    dutIf.i_b     = '0;
    dutIf.i_carry = 1'b0;
    dutIf.i_sub   = 1'b0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.ready", 32'(dutIf.o_ready), 32'd1);
    checkOutput("reset.valid", 32'(dutIf.o_valid), 32'd0);
    checkOutput("reset.sum", 32'(dutIf.o_sum), 32'd0);
    checkOutput("reset.carry", 32'(dutIf.o_carry), 32'd0);
    checkOutput("reset.ovf", 32'(dutIf.o_overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    runVector("add1234", 16'h1234, 16'h0001, 1'b0, 1'b0, 16'h1235, 1'b0, 1'b0, 8);
    runVector("addWrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 8);
    runVector("addOvf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 8);
    runVector("addCin", 16'h00FF, 16'h0F00, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0, 8);
    runVector("sub5m7", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 8);
    runVector("subOvf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 8);
    runVector("subBorrow", 16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0, 8);

    // Result held under backpressure while a new request is offered.
    applyStimulus(16'h0001, 16'h0002, 1'b0, 1'b0, sum, cout, ovf, lat);
    checkOutput("bp.sum", 32'(sum), 32'h0003);
    checkOutput("bp.latency", 32'(lat), 32'd8);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      dutIf.i_valid = 1'b1;
      dutIf.i_a     = 16'hAAAA;
      dutIf.i_b     = 16'h5555;
      dutIf.i_ready = 1'b0;
      @(posedge clk);
      #1;
      checkOutput($sformatf("bp%0d.valid", i), 32'(dutIf.o_valid), 32'd1);
      checkOutput($sformatf("bp%0d.ready", i), 32'(dutIf.o_ready), 32'd0);
      checkOutput($sformatf("bp%0d.sum", i), 32'(dutIf.o_sum), 32'h0003);
    end
    @(negedge clk);
    dutIf.i_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bpRelease.valid", 32'(dutIf.o_valid), 32'd0);
    checkOutput("bpRelease.ready", 32'(dutIf.o_ready), 32'd1);
    checkOutput("bpRelease.sumHeld", 32'(dutIf.o_sum), 32'h0003);
    @(negedge clk);
    dutIf.i_valid = 1'b0;
    dutIf.i_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("bpIdle.valid", 32'(dutIf.o_valid), 32'd0);
    checkOutput("bpIdle.ready", 32'(dutIf.o_ready), 32'd1);

    // Reset arriving on the edge that would process digit 3.
    @(negedge clk);
    dutIf.i_a     = 16'h1234;
    dutIf.i_b     = 16'h1111;
    dutIf.i_carry = 1'b0;
    dutIf.i_sub   = 1'b0;
    dutIf.i_valid = 1'b1;
    @(posedge clk);
    #1;
    dutIf.i_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    dutIf.i_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    dutIf.i_ready = 1'b0;
    checkOutput("midReset.valid", 32'(dutIf.o_valid), 32'd0);
    checkOutput("midReset.ready", 32'(dutIf.o_ready), 32'd1);
    checkOutput("midReset.sum", 32'(dutIf.o_sum), 32'd0);
    checkOutput("midReset.carry", 32'(dutIf.o_carry), 32'd0);
    repeat (12) @(posedge clk);
    #1;
    checkOutput("midReset.discarded", 32'(dutIf.o_valid), 32'd0);
    runVector("afterReset", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 8);

    for (int g = 0; g < 3; g++) begin
      sweepGo[g] = 1'b1;
      wait (sweepDone[g] === 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
